// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD/SUB/NOT/SHL/SHR/AND/OR/SLTU/SGTU) produce a registered
// result on the accept edge. MUL (shift-add) and DIVU/REMU (restoring
// division) iterate one bit per clock for WIDTH clocks before presenting.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready only while idle)
//   a, b, alu_control operands and function select, captured at accept
//   out_valid/out_ready result handshake
//   result, zero, carry, div_by_zero  registered result and flags
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an op; in_ready=1
// BUSY  | MUL/DIVU/REMU iterating, one bit per clock
// DONE  | result and flags presented, held until out_ready
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(2);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(3);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(7);
    localparam logic [OPW-1:0] OP_SGTU = OPW'(8);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(9);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(10);
    localparam logic [OPW-1:0] OP_REMU = OPW'(11);

    localparam logic [WIDTH-1:0] W_VAL  = WIDTH[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SGT_T  = WIDTH'(8);
    localparam logic [WIDTH-1:0] SGT_F  = WIDTH'(9);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;      // MUL partial product / DIV partial remainder
    logic [WIDTH-1:0] work_a;   // MUL shifted multiplicand / DIV dividend->quotient
    logic [WIDTH-1:0] work_b;   // MUL shifted multiplier
    logic [CNT_W-1:0] cnt;

    logic             is_multi;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             q_bit;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] work_a_next;
    logic [WIDTH-1:0] work_b_next;
    logic [WIDTH-1:0] mc_res;
    logic             mc_dbz;

    assign is_multi = (alu_control == OP_MUL) || (alu_control == OP_DIVU) ||
                      (alu_control == OP_REMU);

    // Single-cycle function unit, evaluated on the live inputs at accept.
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = 1'b0;
        case (alu_control)
            OP_ADD: begin
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                sc_res   = a - b;
                sc_carry = (a >= b);
            end
            OP_NOT:  sc_res = ~a;
            OP_SHL:  sc_res = (b >= W_VAL) ? '0 : (a << b);
            OP_SHR:  sc_res = (b >= W_VAL) ? '0 : (a >> b);
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SLTU: sc_res = WIDTH'(a < b);
            OP_SGTU: sc_res = (a > b) ? SGT_T : SGT_F;
            default: begin
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
            end
        endcase
    end

    // One iteration of the multi-cycle engine. The terminal iteration's
    // outputs feed the result directly so the result lands on that edge.
    always_comb begin
        div_shift   = {acc, work_a[WIDTH-1]};
        div_diff    = div_shift - {1'b0, b_r};
        q_bit       = ~div_diff[WIDTH];
        acc_next    = acc;
        work_a_next = work_a;
        work_b_next = work_b;
        if (op_r == OP_MUL) begin
            acc_next    = work_b[0] ? (acc + work_a) : acc;
            work_a_next = work_a << 1;
            work_b_next = work_b >> 1;
        end else begin
            acc_next    = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_a_next = {work_a[WIDTH-2:0], q_bit};
        end
    end

    // Divide by zero overrides whatever the engine produced.
    always_comb begin
        mc_dbz = (op_r != OP_MUL) && (b_r == '0);
        case (op_r)
            OP_MUL:  mc_res = acc_next;
            OP_DIVU: mc_res = (b_r == '0) ? '1 : work_a_next;
            default: mc_res = (b_r == '0) ? a_r : acc_next;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = is_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            work_a      <= '0;
            work_b      <= '0;
            cnt         <= '0;
            result      <= '0;
            zero        <= 1'b1;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r <= alu_control;
                        a_r  <= a;
                        b_r  <= b;
                        if (is_multi) begin
                            cnt    <= CNT_W'(WIDTH - 1);
                            acc    <= '0;
                            work_a <= a;
                            work_b <= b;
                        end else begin
                            result      <= sc_res;
                            zero        <= (sc_res == '0);
                            carry       <= sc_carry;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next;
                    work_a <= work_a_next;
                    work_b <= work_b_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        result      <= mc_res;
                        zero        <= (mc_res == '0);
                        carry       <= 1'b0;
                        div_by_zero <= mc_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        d;
    } exp_t;

    exp_t sb_q[$];

    alu_seq #(.WIDTH(16), .OPW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .carry       (carry),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares the presented result on each completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
                chk({e.name, "_zero"},  {31'h0, zero},        {31'h0, e.z});
                chk({e.name, "_carry"}, {31'h0, carry},       {31'h0, e.c});
                chk({e.name, "_dbz"},   {31'h0, div_by_zero}, {31'h0, e.d});
            end
        end
    end

    // Issue one op, check its latency, optionally hold out_ready low for
    // 'hold' clocks once the result is presented, then complete the handshake.
    task automatic do_op(input string nm, input logic [3:0] op,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic ez, input logic ec,
                         input logic ed, input int elat, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk({nm, "_in_ready_timeout"}, 32'd0, 32'd1);
        e.name = nm; e.res = er; e.z = ez; e.c = ec; e.d = ed;
        sb_q.push_back(e);
        out_ready   = (hold == 0);
        in_valid    = 1'b1;
        a           = av;
        b           = bv;
        alu_control = op;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        a           = 16'hA5A5;
        b           = 16'h5A5A;
        alu_control = 4'h6;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, elat);
        for (int i = 0; i < hold; i++) begin
            chk({nm, "_hold_valid"},  {31'h0, out_valid}, 32'd1);
            chk({nm, "_hold_inrdy"},  {31'h0, in_ready},  32'd0);
            chk({nm, "_hold_result"}, {16'h0, result},    {16'h0, er});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_in_ready_after"},  {31'h0, in_ready},  32'd1);
        chk({nm, "_out_valid_after"}, {31'h0, out_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        alu_control = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'h0, in_ready},    32'd1);
        chk("rst_out_valid", {31'h0, out_valid},   32'd0);
        chk("rst_result",    {16'h0, result},      32'd0);
        chk("rst_zero",      {31'h0, zero},        32'd1);
        chk("rst_carry",     {31'h0, carry},       32'd0);
        chk("rst_dbz",       {31'h0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //     name         op     a         b         result    z     c     d    lat hold
        do_op("add_wrap",  4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1,  0);
        do_op("sub_pos",   4'h1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b1, 1'b0, 1,  0);
        do_op("sub_neg",   4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("sub_eq",    4'h1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1,  0);
        do_op("not",       4'h2, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("shl_16",    4'h3, 16'h0001, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1,  0);
        do_op("shl_4",     4'h3, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("shr_15",    4'h4, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("shr_big",   4'h4, 16'h8000, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1,  0);
        do_op("and",       4'h5, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("or",        4'h6, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("sltu_t",    4'h7, 16'h0003, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("sltu_f",    4'h7, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1,  0);
        do_op("sgtu_bp",   4'h8, 16'h0003, 16'h0002, 16'h0008, 1'b0, 1'b0, 1'b0, 1,  3);
        do_op("sgtu_f",    4'h8, 16'h0002, 16'h0003, 16'h0009, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("op_f_add",  4'hF, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1,  0);
        do_op("mul_300",   4'h9, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 1'b0, 17, 0);
        do_op("mul_ffff",  4'h9, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 17, 0);
        do_op("mul_zero",  4'h9, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 17, 0);
        do_op("divu_100",  4'hA, 16'd100,  16'd7,    16'h000E, 1'b0, 1'b0, 1'b0, 17, 0);
        do_op("remu_100",  4'hB, 16'd100,  16'd7,    16'h0002, 1'b0, 1'b0, 1'b0, 17, 0);
        do_op("divu_small",4'hA, 16'd7,    16'd100,  16'h0000, 1'b1, 1'b0, 1'b0, 17, 0);
        do_op("divu_big",  4'hA, 16'hFFFF, 16'h0003, 16'h5555, 1'b0, 1'b0, 1'b0, 17, 2);
        do_op("divu_z",    4'hA, 16'd5,    16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b1, 17, 0);
        do_op("remu_z",    4'hB, 16'd5,    16'd0,    16'h0005, 1'b0, 1'b0, 1'b1, 17, 0);
        do_op("add_after", 4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1,  0);

        // Abort a MUL mid-flight with reset; nothing is queued for it.
        in_valid    = 1'b1;
        a           = 16'd300;
        b           = 16'd300;
        alu_control = 4'h9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy", {31'h0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'h0, in_ready},  32'd1);
        chk("abort_result",    {16'h0, result},    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("add_post_rst", 4'h0, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b0, 1'b0, 1, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
